serial_subtractor4: RTL and testbench
=====================================

SERIAL_SUBTRACTOR4 -- requirements
Module: serial_subtractor4

Interface
REQ-001 Parameters SHALL be none; operand width is fixed at 4 bits.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a0, a1, a2, a3  input  1 each  minuend A, a0 = LSB, high active.
REQ-006 b0, b1, b2, b3  input  1 each  subtrahend B, a0/b0 = LSB, high active.
REQ-007 bin  input  1  borrow input.
REQ-008 d0, d1, d2, d3  output  1 each  difference D, registered.
REQ-009 bout  output  1  borrow output, registered.
REQ-010 busy  output  1  high while in SHIFT.
REQ-011 done  output  1  one-cycle pulse when D/bout become valid.

Function
REQ-012 Result SHALL satisfy {bout,D} = A - B - bin mod 32, with bout=1 exactly when A < B + bin (unsigned).
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-014 IDLE + start=1 at edge E0 SHALL latch A, B and bin into internal registers, clear the bit counter to 0, and enter SHIFT.
REQ-015 In SHIFT, each edge SHALL process one bit k (LSB first), using the latched borrow br:
- d_k = a_k ^ b_k ^ br
- br' = (~a_k & b_k) | (~(a_k ^ b_k) & br)
REQ-016 The bit counter SHALL increment by 1 on each SHIFT edge.
REQ-017 After the 4th SHIFT edge (E4), the FSM SHALL enter DONE.
REQ-018 In DONE, D and bout SHALL show the final result, done=1 for exactly that one cycle, then the FSM returns to IDLE at E5.
REQ-019 Latency SHALL be 4 cycles from the start edge to done high.
REQ-020 The minimum start-to-start spacing SHALL be 6 cycles.
REQ-021 busy SHALL be 1 in SHIFT only.
REQ-022 start SHALL be ignored in SHIFT and DONE; there is no queueing.
REQ-023 Operand inputs SHALL be don't-care after E0; changing them mid-operation SHALL NOT affect the result.
REQ-024 Outputs D and bout SHALL hold the last completed result in IDLE until the next operation reaches DONE.
REQ-025 During SHIFT, D and bout are internal working values and SHALL be treated as invalid until done=1.
REQ-026 Operand 0 - 0 with bin=0 SHALL produce D=0000, bout=0; 15 - 0 SHALL produce D=1111, bout=0.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE, counter=0, internal operands=0, borrow=0.
REQ-028 rst=1 at any edge SHALL force d0..d3=0, bout=0, busy=0, done=0.
REQ-029 Reset SHALL take priority over start and over any in-flight operation; an aborted operation SHALL produce no done pulse.
REQ-030 start=1 in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-031 Macro SERIAL_SUBTRACTOR4_OVF_EN defined: the block SHALL add output port ovf (1 bit, registered), the signed two's-complement overflow flag, computed as (a3 ^ b3) & (a3 ^ d3) from latched operands and final D.
REQ-032 ovf SHALL be valid with done, held alongside D, and reset to 0.
REQ-033 Macro SERIAL_SUBTRACTOR4_OVF_EN undefined: the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 A=9, B=3, bin=0, start pulse -> done exactly 4 cycles later; D=0110, bout=0, busy high 4 cycles.
REQ-035 A=3, B=9, bin=0 -> D=1010, bout=1; A=0, B=0, bin=1 -> D=1111, bout=1.
REQ-036 start held high continuously with A=5, B=2 -> one operation per 6 cycles, each D=0011; start pulses during SHIFT/DONE produce no extra done.
REQ-037 Reset test: rst=1 at 2nd SHIFT edge of A=12, B=4 -> next cycle all outputs 0, no done pulse.
REQ-038 Reset test, continued: a subsequent 12-4 -> D=1000, bout=0.
REQ-039 With SERIAL_SUBTRACTOR4_OVF_EN: A=0111, B=1000, bin=0 -> D=1111, bout=1, ovf=1; A=0110, B=0010 -> D=0100, ovf=0.

Source files
------------

// File: rtl/serial_subtractor4_if.sv
// Operand/result bundle for serial_subtractor4.
// Optional port ovf exists only when SERIAL_SUBTRACTOR4_OVF_EN is defined.
interface serial_subtractor4_if;
  logic start;
  logic a0, a1, a2, a3;
  logic b0, b1, b2, b3;
  logic bin;
  logic d0, d1, d2, d3;
  logic bout;
  logic busy;
  logic done;
`ifdef SERIAL_SUBTRACTOR4_OVF_EN
  logic ovf;

  modport master (
    output start, a0, a1, a2, a3, b0, b1, b2, b3, bin,
    input  d0, d1, d2, d3, bout, busy, done, ovf
  );

  modport slave (
    input  start, a0, a1, a2, a3, b0, b1, b2, b3, bin,
    output d0, d1, d2, d3, bout, busy, done, ovf
  );
`else
  modport master (
    output start, a0, a1, a2, a3, b0, b1, b2, b3, bin,
    input  d0, d1, d2, d3, bout, busy, done
  );

  modport slave (
    input  start, a0, a1, a2, a3, b0, b1, b2, b3, bin,
    output d0, d1, d2, d3, bout, busy, done
  );
`endif
endinterface

// File: rtl/serial_subtractor4.sv
// 4-bit bit-serial subtractor: {bout,D} = A - B - bin, one bit per cycle, LSB first.
// Define SERIAL_SUBTRACTOR4_OVF_EN to add the registered signed-overflow flag ovf.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// SHIFT | processing bit cnt_q of the latched operands
// DONE  | result valid on outputs, done pulses for this one cycle
module serial_subtractor4 (
  input logic             clk,
  input logic             rst,
  serial_subtractor4_if.slave sif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q;
  logic [3:0] a_q, b_q;
  logic [3:0] wd_q;
  logic       br_q;
  logic [3:0] d_q;
  logic       bout_q;
  logic       a_k, b_k, d_k, br_k;
  logic       last_bit;

  // Current bit slice of the latched operands and its full-subtractor result.
  assign a_k      = a_q[cnt_q];
  assign b_k      = b_q[cnt_q];
  assign d_k      = a_k ^ b_k ^ br_q;
  assign br_k     = (~a_k & b_k) | (~(a_k ^ b_k) & br_q);
  assign last_bit = (cnt_q == 2'd3);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; start is only looked at in IDLE so nothing queues.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sif.start) state_d = SHIFT;
      SHIFT:   if (last_bit)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state.
  always_comb begin
    sif.busy = 1'b0;
    sif.done = 1'b0;
    case (state_q)
      SHIFT:   sif.busy = 1'b1;
      DONE:    sif.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch on start, shift into a working register, and only copy
  // to the output registers on the final bit so D/bout hold the previous
  // result for the whole of SHIFT.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      a_q    <= 4'd0;
      b_q    <= 4'd0;
      wd_q   <= 4'd0;
      br_q   <= 1'b0;
      d_q    <= 4'd0;
      bout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sif.start) begin
            a_q   <= {sif.a3, sif.a2, sif.a1, sif.a0};
            b_q   <= {sif.b3, sif.b2, sif.b1, sif.b0};
            br_q  <= sif.bin;
            cnt_q <= 2'd0;
          end
        end
        SHIFT: begin
          wd_q[cnt_q] <= d_k;
          br_q        <= br_k;
          cnt_q       <= cnt_q + 2'd1;
          if (last_bit) begin
            d_q    <= {d_k, wd_q[2:0]};
            bout_q <= br_k;
          end
        end
        default: ;
      endcase
    end
  end

  assign sif.d0   = d_q[0];
  assign sif.d1   = d_q[1];
  assign sif.d2   = d_q[2];
  assign sif.d3   = d_q[3];
  assign sif.bout = bout_q;

`ifdef SERIAL_SUBTRACTOR4_OVF_EN
  logic ovf_q;

  // Signed overflow: operand signs differ and the result sign differs from A.
  always_ff @(posedge clk) begin
    if (rst)
      ovf_q <= 1'b0;
    else if (state_q == SHIFT && last_bit)
      ovf_q <= (a_q[3] ^ b_q[3]) & (a_q[3] ^ d_k);
  end

  assign sif.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor4.sv
// Directed, table-driven bench for serial_subtractor4.
// Checks ovf as well when SERIAL_SUBTRACTOR4_OVF_EN is defined.
module tb_serial_subtractor4;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  serial_subtractor4_if sif();

  serial_subtractor4 dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] exp_d;
    logic       exp_bout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ops(input logic [3:0] a, input logic [3:0] b, input logic bi);
    {sif.a3, sif.a2, sif.a1, sif.a0} = a;
    {sif.b3, sif.b2, sif.b1, sif.b0} = b;
    sif.bin = bi;
  endtask

  function automatic logic [3:0] dval();
    return {sif.d3, sif.d2, sif.d1, sif.d0};
  endfunction

  // One full operation; operands are scrambled right after the start edge.
  task automatic do_op(input vec_t v);
    int lat;
    int nb;
    @(negedge clk);
    set_ops(v.a, v.b, v.bin);
    sif.start = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    set_ops(~v.a, ~v.b, ~v.bin);
    nb  = sif.busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (sif.done) begin
        lat = k;
        break;
      end
      if (sif.busy) nb++;
    end
    chk("latency", lat, 4);
    chk("busy_cycles", nb, 4);
    chk("d", int'(dval()), int'(v.exp_d));
    chk("bout", int'(sif.bout), int'(v.exp_bout));
`ifdef SERIAL_SUBTRACTOR4_OVF_EN
    chk("ovf", int'(sif.ovf), int'(v.exp_ovf));
`endif
    @(posedge clk);
    #1;
    chk("done_one_cycle", int'(sif.done), 0);
    chk("busy_after_done", int'(sif.busy), 0);
  endtask

  initial begin
    int ndone;
    n_vec = 0;
    n_err = 0;

    //           a      b      bin   d        bout  ovf
    vecs[0]  = '{4'd9,  4'd3,  1'b0, 4'b0110, 1'b0, 1'b1};
    vecs[1]  = '{4'd3,  4'd9,  1'b0, 4'b1010, 1'b1, 1'b1};
    vecs[2]  = '{4'd0,  4'd0,  1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[3]  = '{4'd0,  4'd0,  1'b0, 4'b0000, 1'b0, 1'b0};
    vecs[4]  = '{4'd15, 4'd0,  1'b0, 4'b1111, 1'b0, 1'b0};
    vecs[5]  = '{4'd12, 4'd4,  1'b0, 4'b1000, 1'b0, 1'b0};
    vecs[6]  = '{4'd7,  4'd8,  1'b0, 4'b1111, 1'b1, 1'b1};
    vecs[7]  = '{4'd6,  4'd2,  1'b0, 4'b0100, 1'b0, 1'b0};
    vecs[8]  = '{4'd8,  4'd8,  1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[9]  = '{4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, 1'b0};
    vecs[10] = '{4'd10, 4'd5,  1'b1, 4'b0100, 1'b0, 1'b1};
    vecs[11] = '{4'd0,  4'd15, 1'b0, 4'b0001, 1'b1, 1'b0};
    vecs[12] = '{4'd5,  4'd2,  1'b0, 4'b0011, 1'b0, 1'b0};

    // Reset with start asserted: start must be ignored.
    rst       = 1'b1;
    sif.start = 1'b1;
    set_ops(4'd9, 4'd3, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d", int'(dval()), 0);
    chk("rst_bout", int'(sif.bout), 0);
    chk("rst_busy", int'(sif.busy), 0);
    chk("rst_done", int'(sif.done), 0);
`ifdef SERIAL_SUBTRACTOR4_OVF_EN
    chk("rst_ovf", int'(sif.ovf), 0);
`endif
    @(negedge clk);
    rst       = 1'b0;
    sif.start = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_rst", int'(sif.busy), 0);

    for (int i = 0; i < 13; i++) do_op(vecs[i]);

    // Result holds through idle cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("hold_d", int'(dval()), 3);

    // start held high: one operation every 6 cycles.
    @(negedge clk);
    set_ops(4'd5, 4'd2, 1'b0);
    sif.start = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk);
      #1;
      chk("held_start_done", int'(sif.done), ((k % 6) == 4) ? 1 : 0);
      if ((k % 6) == 4) chk("held_start_d", int'(dval()), 3);
    end
    @(negedge clk);
    sif.start = 1'b0;
    repeat (2) @(posedge clk);

    // Reset at the second SHIFT edge of 12-4, with start also high.
    @(negedge clk);
    set_ops(4'd12, 4'd4, 1'b0);
    sif.start = 1'b1;
    @(posedge clk);
    #1;
    sif.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    sif.start = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_d", int'(dval()), 0);
    chk("abort_bout", int'(sif.bout), 0);
    chk("abort_busy", int'(sif.busy), 0);
    chk("abort_done", int'(sif.done), 0);
    @(negedge clk);
    rst       = 1'b0;
    sif.start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (sif.done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_op(vecs[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
